// File: rtl/brick_move_scheduler.sv
// brick_move_scheduler
//   Sequencing controller for the playing-field datapath. Latches one-cycle
//   keyboard requests plus an internal gravity tick. It arbitrates them into
//   one move transaction at a time: try -> check -> commit, or lock ->
//   place -> clear -> spawn. It raises a sticky game-over when a freshly
//   spawned brick collides.
//
// Ports
//   main_clk        system clock
//   rst_1plus       asynchronous, active-high reset
//   enable          high while the game is in PLAYING
//   key_rot/down/left/right/drop  one-cycle key pulses
//   chk_collided    collision result for the last loaded try (valid in CHECK)
//   spawn_collided  collision result for the next brick at spawn (valid in SPAWN)
//   try_op          0 NONE, 1 ROT, 2 DOWN, 3 LEFT, 4 RIGHT
//   try_load        datapath loads try position/direction from cur + try_op
//   commit          datapath copies try into cur
//   place           write shadow brick into the board
//   clear           load the line-cleared board
//   spawn           load a new brick at the spawn position
//   game_over       sticky loss flag
//   state           current FSM state (debug display)
module brick_move_scheduler #(
  parameter int GRAV_TICKS = 3052,
  parameter int GRAV_W     = 12
) (
  input  logic       main_clk,
  input  logic       rst_1plus,
  input  logic       enable,
  input  logic       key_rot,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_drop,
  input  logic       chk_collided,
  input  logic       spawn_collided,
  output logic [2:0] try_op,
  output logic       try_load,
  output logic       commit,
  output logic       place,
  output logic       clear,
  output logic       spawn,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_ISSUE = 3'd1,
    S_CHECK = 3'd2,
    S_PLACE = 3'd3,
    S_CLEAR = 3'd4,
    S_SPAWN = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_ROT   = 3'd1;
  localparam logic [2:0] OP_DOWN  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  localparam logic [GRAV_W-1:0] GRAV_LAST = GRAV_W'(GRAV_TICKS - 1);

  state_t            cur_state;
  state_t            nxt_state;

  // Request vectors are ordered by priority, bit 0 highest:
  // [0] drop, [1] rot, [2] left, [3] right, [4] down, [5] gravity.
  logic [5:0]        pend;
  logic [5:0]        pend_nxt;
  logic [5:0]        key_vec;
  logic [5:0]        set_vec;
  logic [5:0]        req;
  logic [5:0]        sel;
  logic              serve;
  logic [2:0]        op_sel;

  logic [GRAV_W-1:0] grav_cnt;
  logic              grav_zero;
  logic              grav_run;
  logic              grav_wrap;
  logic              down_commit;

  // Request arbitration
  always_comb begin
    key_vec = {1'b0, key_down, key_right, key_left, key_rot, key_drop};
    // Keys pulsing this cycle compete immediately. This gives a one-cycle
    // hop from pulse to ISSUE. Gravity competes only once it is latched.
    req     = pend | key_vec;
    serve   = (cur_state == S_WAIT) && enable;
    // Isolate the lowest set bit, which is the highest-priority request.
    sel     = serve ? (req & (~req + 6'd1)) : 6'd0;
    set_vec = ((cur_state != S_OVER) ? key_vec : 6'd0) | {grav_wrap, 5'd0};
    // A served flag survives only if a fresh event for it arrived on top of
    // an already-pending one. A pulse that was itself the request is consumed.
    if (cur_state == S_SPAWN) begin
      pend_nxt = 6'd0;
    end else begin
      pend_nxt = (~sel & (pend | set_vec)) | (sel & pend & set_vec);
    end
  end

  always_comb begin
    op_sel = OP_NONE;
    if (sel[1])               op_sel = OP_ROT;
    else if (sel[2])          op_sel = OP_LEFT;
    else if (sel[3])          op_sel = OP_RIGHT;
    else if (sel[4] | sel[5]) op_sel = OP_DOWN;
  end

  // Gravity timer
  always_comb begin
    down_commit = (cur_state == S_CHECK) && !chk_collided && (try_op == OP_DOWN);
    grav_zero   = down_commit || (cur_state == S_SPAWN);
    grav_run    = enable && (cur_state != S_OVER);
    grav_wrap   = !grav_zero && grav_run && (grav_cnt == GRAV_LAST);
  end

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      grav_cnt <= '0;
    end else if (grav_zero || grav_wrap) begin
      grav_cnt <= '0;
    end else if (grav_run) begin
      grav_cnt <= grav_cnt + 1'b1;
    end
  end

  // Control registers: pending flags, latched op, loss flag
  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      pend      <= 6'd0;
      try_op    <= OP_NONE;
      game_over <= 1'b0;
    end else begin
      pend <= pend_nxt;
      // Drop bypasses the try/check path, so it leaves try_op untouched.
      if (op_sel != OP_NONE) begin
        try_op <= op_sel;
      end
      if ((cur_state == S_SPAWN) && spawn_collided) begin
        game_over <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      cur_state <= S_WAIT;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      S_WAIT: begin
        if (sel[0])             nxt_state = S_PLACE;
        else if (sel != 6'd0)   nxt_state = S_ISSUE;
      end
      S_ISSUE: nxt_state = S_CHECK;
      S_CHECK: begin
        if (chk_collided && (try_op == OP_DOWN)) nxt_state = S_PLACE;
        else                                     nxt_state = S_WAIT;
      end
      S_PLACE: nxt_state = S_CLEAR;
      S_CLEAR: nxt_state = S_SPAWN;
      S_SPAWN: nxt_state = spawn_collided ? S_OVER : S_WAIT;
      S_OVER:  nxt_state = S_OVER;
      default: nxt_state = S_WAIT;
    endcase
  end

  // FSM outputs: strobes decode the current state only, so an
  // asynchronous reset silences them immediately.
  always_comb begin
    try_load = (cur_state == S_ISSUE);
    commit   = (cur_state == S_CHECK) && !chk_collided;
    place    = (cur_state == S_PLACE);
    clear    = (cur_state == S_CLEAR);
    spawn    = (cur_state == S_SPAWN);
    state    = cur_state;
  end

endmodule

// File: tb/tb_brick_move_scheduler.sv
// Testbench for brick_move_scheduler. A transaction-level reference model
// (pending-request set, gravity count, and a queue of scripted per-cycle
// phases for the transaction in flight) predicts every output cycle by cycle.
module tb_brick_move_scheduler;

  localparam int GT = 8;

  logic       main_clk = 1'b0;
  logic       rst_1plus = 1'b1;
  logic       enable = 1'b0;
  logic       key_rot = 1'b0, key_down = 1'b0, key_left = 1'b0;
  logic       key_right = 1'b0, key_drop = 1'b0;
  logic       chk_collided = 1'b0, spawn_collided = 1'b0;
  logic [2:0] try_op, state;
  logic       try_load, commit, place, clear, spawn, game_over;

  int n_vec = 0;
  int n_err = 0;

  brick_move_scheduler #(.GRAV_TICKS(GT), .GRAV_W(4)) dut (
    .main_clk      (main_clk),
    .rst_1plus     (rst_1plus),
    .enable        (enable),
    .key_rot       (key_rot),
    .key_down      (key_down),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_drop      (key_drop),
    .chk_collided  (chk_collided),
    .spawn_collided(spawn_collided),
    .try_op        (try_op),
    .try_load      (try_load),
    .commit        (commit),
    .place         (place),
    .clear         (clear),
    .spawn         (spawn),
    .game_over     (game_over),
    .state         (state)
  );

  always #5 main_clk = ~main_clk;

  // Key vector bit order used by the bench: [0] drop [1] rot [2] left [3] right [4] down
  localparam bit [4:0] K_DROP = 5'b00001, K_ROT = 5'b00010, K_LEFT = 5'b00100;
  localparam bit [4:0] K_RIGHT = 5'b01000, K_DOWN = 5'b10000, K_NONE = 5'b00000;

  // Reference model
  int       q_st[$];
  bit       q_chk[$];
  bit       q_spc[$];
  bit [5:0] m_pend;
  int       m_cnt;
  int       m_op;
  bit       m_over;
  int       col_mode;   // 0 never, 1 random, 2 always
  int       spc_mode;
  int       n_commit;
  int       cyc;
  int       tl_hist[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit pick(input int mode, input int pct);
    if (mode == 2) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 99) < pct);
    return 1'b0;
  endfunction

  task automatic push(input int st, input bit c, input bit s);
    q_st.push_back(st);
    q_chk.push_back(c);
    q_spc.push_back(s);
  endtask

  task automatic model_clear();
    q_st.delete(); q_chk.delete(); q_spc.delete();
    m_pend = '0; m_cnt = 0; m_op = 0; m_over = 1'b0;
  endtask

  // One clock cycle: drive, check at posedge+3, advance model, wait for edge.
  task automatic step(input bit [4:0] k, input bit en);
    int cur;
    int sel;
    bit c, s, wrap, crst, coll;
    bit [5:0] kv, req;
    key_drop = k[0]; key_rot = k[1]; key_left = k[2]; key_right = k[3]; key_down = k[4];
    enable = en;
    cur = m_over ? 6 : ((q_st.size() > 0) ? q_st[0] : 0);
    c = (cur == 2) ? q_chk[0] : 1'($urandom_range(0, 1));
    s = (cur == 5) ? q_spc[0] : 1'($urandom_range(0, 1));
    chk_collided = c;
    spawn_collided = s;
    #2;
    chk("state", {5'd0, state}, 8'(cur));
    chk("try_load", {7'd0, try_load}, {7'd0, cur == 1});
    chk("commit", {7'd0, commit}, {7'd0, (cur == 2) && !c});
    chk("place", {7'd0, place}, {7'd0, cur == 3});
    chk("clear", {7'd0, clear}, {7'd0, cur == 4});
    chk("spawn", {7'd0, spawn}, {7'd0, cur == 5});
    chk("game_over", {7'd0, game_over}, {7'd0, m_over});
    chk("try_op", {5'd0, try_op}, 8'(m_op));
    if (commit === 1'b1) n_commit++;
    if (try_load === 1'b1) tl_hist.push_back(cyc);
    if (!m_over) begin
      kv = {1'b0, k};
      crst = ((cur == 2) && !c && (m_op == 2)) || (cur == 5);
      wrap = 1'b0;
      if (crst) m_cnt = 0;
      else if (en) begin
        if (m_cnt == GT - 1) begin m_cnt = 0; wrap = 1'b1; end
        else m_cnt++;
      end
      if (cur != 0) begin
        void'(q_st.pop_front()); void'(q_chk.pop_front()); void'(q_spc.pop_front());
      end
      if (cur == 0 && en) begin
        req = m_pend | kv;
        sel = -1;
        for (int i = 0; i < 6; i++) if (sel < 0 && req[i]) sel = i;
        kv[5] = wrap;
        for (int i = 0; i < 6; i++)
          m_pend[i] = (i == sel) ? (m_pend[i] & kv[i]) : (m_pend[i] | kv[i]);
        if (sel == 0) begin
          push(3, 0, 0); push(4, 0, 0); push(5, 0, pick(spc_mode, 5));
        end else if (sel > 0) begin
          m_op = (sel == 1) ? 1 : (sel == 2) ? 3 : (sel == 3) ? 4 : 2;
          coll = pick(col_mode, 30);
          push(1, 0, 0); push(2, coll, 0);
          if (coll && m_op == 2) begin
            push(3, 0, 0); push(4, 0, 0); push(5, 0, pick(spc_mode, 5));
          end
        end
      end else begin
        kv[5] = wrap;
        m_pend = m_pend | kv;
      end
      if (cur == 5) begin
        m_pend = '0;
        if (s) m_over = 1'b1;
      end
    end
    cyc++;
    @(posedge main_clk);
    #1;
  endtask

  // Reset asserted asynchronously mid-cycle; outputs must drop at once.
  task automatic do_reset();
    key_drop = 0; key_rot = 0; key_left = 0; key_right = 0; key_down = 0;
    enable = 1'b1;
    chk_collided = 1'b0;
    #2;
    rst_1plus = 1'b1;
    #1;
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_commit", {7'd0, commit}, 8'd0);
    chk("rst_try_load", {7'd0, try_load}, 8'd0);
    chk("rst_strobes", {5'd0, place, clear, spawn}, 8'd0);
    chk("rst_game_over", {7'd0, game_over}, 8'd0);
    chk("rst_try_op", {5'd0, try_op}, 8'd0);
    @(posedge main_clk);
    #1;
    rst_1plus = 1'b0;
    model_clear();
  endtask

  initial begin
    bit [4:0] k;
    model_clear();
    col_mode = 0; spc_mode = 0; n_commit = 0; cyc = 0;
    @(posedge main_clk);
    #1;

    // Single LEFT move: latched at cycle 5, try_load at 6, commit at 7, WAIT at 8
    do_reset();
    repeat (5) step(K_NONE, 1'b1);
    step(K_LEFT, 1'b1);
    repeat (4) step(K_NONE, 1'b1);

    // Three simultaneous keys become three back-to-back transactions
    do_reset();
    n_commit = 0;
    step(K_ROT | K_LEFT | K_RIGHT, 1'b1);
    repeat (8) step(K_NONE, 1'b1);
    chk("three_commits", 8'(n_commit), 8'd3);

    // Gravity alone, then a colliding gravity DOWN locks the brick
    do_reset();
    tl_hist.delete();
    cyc = 0;
    repeat (40) step(K_NONE, 1'b1);
    chk("grav_count", 8'(tl_hist.size()), 8'd3);
    for (int i = 1; i < tl_hist.size(); i++)
      chk("grav_period", 8'(tl_hist[i] - tl_hist[i-1]), 8'd11);
    col_mode = 2;
    repeat (16) step(K_NONE, 1'b1);
    col_mode = 0;

    // Drop together with rotate: straight to PLACE, rotate discarded at SPAWN
    do_reset();
    tl_hist.delete();
    step(K_DROP | K_ROT, 1'b1);
    repeat (6) step(K_NONE, 1'b1);
    chk("drop_no_try", 8'(tl_hist.size()), 8'd0);

    // Spawn collision ends the game; keys and gravity are ignored afterwards
    do_reset();
    col_mode = 2; spc_mode = 2;
    step(K_DOWN, 1'b1);
    for (int i = 0; i < 30; i++) step(5'($urandom_range(0, 31)), 1'b1);
    chk("over_state", {5'd0, state}, 8'd6);
    col_mode = 0; spc_mode = 0;

    // Reset asserted during CHECK; the next key is serviced normally
    do_reset();
    step(K_LEFT, 1'b1);
    step(K_NONE, 1'b1);
    chk_collided = 1'b0;
    #1;
    chk("pre_rst_state", {5'd0, state}, 8'd2);
    chk("pre_rst_commit", {7'd0, commit}, 8'd1);
    do_reset();
    step(K_RIGHT, 1'b1);
    repeat (4) step(K_NONE, 1'b1);

    // enable low holds WAIT while requests stay pending
    do_reset();
    step(K_LEFT, 1'b0);
    repeat (3) step(K_NONE, 1'b0);
    repeat (4) step(K_NONE, 1'b1);

    // Randomised run
    do_reset();
    col_mode = 1; spc_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) k[b] = ($urandom_range(0, 99) < 8);
      step(k, ($urandom_range(0, 9) != 0));
      if ((m_over && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/brick_move_scheduler.md
Name: brick_move_scheduler

Overview:
- Sequencing controller for the playing-field datapath: try-register, collision checker, board placement, line clear and new-brick spawn.
- Latches one-cycle keyboard requests and an internal gravity tick. Arbitrates them into one move transaction at a time.
- Issues try/commit/place/clear/spawn strobes to the datapath and raises game-over when a spawned brick collides.
- Replaces the ad-hoc WAIT/CAL_POS/PLACE/CLEAR/GEN_NEW_BLOCK sequencing inside the top level.

Parameters:
- GRAV_TICKS, 3052: main_clk cycles between gravity down-requests (about 1 s at main_clk).
- GRAV_W, 12: gravity counter width; must satisfy 2^GRAV_W > GRAV_TICKS.

Ports:
- main_clk  in  1  system clock for all state.
- rst_1plus  in  1  asynchronous, active-high reset.
- enable  in  1  high while the game state is PLAYING.
- key_rot, key_down, key_left, key_right, key_drop  in  1 each  one-cycle key pulses.
- chk_collided  in  1  registered collision result for the last loaded try; valid in CHECK.
- spawn_collided  in  1  registered collision result for the next brick at the spawn position; valid in SPAWN.
- try_op  out  3  0 NONE, 1 ROT, 2 DOWN, 3 LEFT, 4 RIGHT.
- try_load  out  1  datapath loads try_pos/try_dir from cur + try_op.
- commit  out  1  datapath copies try into cur.
- place  out  1  write shadow brick into board.
- clear  out  1  load cleared board.
- spawn  out  1  load new brick at spawn position.
- game_over  out  1  sticky loss flag.
- state  out  3  current FSM state, for the seven-segment debug display.

Behaviour:
- Reset is asynchronous on rst_1plus:
  - state=WAIT; all pending flags=0; gravity counter=0; try_op=NONE; game_over=0; all strobes 0.
  - Reset mid-transaction abandons the transaction; no strobe is emitted after reset asserts.
- State encoding: WAIT=0, ISSUE=1, CHECK=2, PLACE=3, CLEAR=4, SPAWN=5, OVER=6.
- Pending request flags (pend_drop, pend_rot, pend_left, pend_right, pend_down, pend_grav):
  - Set on the corresponding key pulse in any state except OVER.
  - Simultaneous pulses all latch.
  - A flag clears only when it is selected for service. A pulse arriving in the same cycle its flag is served re-sets it, so the request is not lost.
- Gravity counter:
  - Increments each cycle while enable=1 and state is not OVER.
  - At GRAV_TICKS-1 it wraps to 0 and sets pend_grav.
  - Also resets to 0 on any DOWN commit and on spawn.
- WAIT:
  - If enable=0, stay in WAIT.
  - Otherwise select the highest-priority pending request: drop > rot > left > right > down > grav. Clear its flag.
  - drop: next state PLACE.
  - Other requests: latch try_op (grav maps to DOWN) and go to ISSUE.
  - No pending request: stay in WAIT.
- ISSUE (one cycle): try_load=1 with the latched try_op; next state CHECK.
- CHECK (one cycle):
  - chk_collided=0: commit=1; next state WAIT.
  - chk_collided=1 and try_op=DOWN: next state PLACE (lock).
  - chk_collided=1 and any other op: next state WAIT, no commit.
- PLACE: place=1 for one cycle; next CLEAR.
- CLEAR: clear=1 for one cycle; next SPAWN.
- SPAWN:
  - spawn=1 for one cycle.
  - spawn_collided=1: set game_over, next OVER.
  - spawn_collided=0: next WAIT.
  - Clear all pending flags so no stale input is applied to the new brick.
- OVER: hold state; game_over=1; all strobes 0; key pulses ignored. Exit only by reset.
- try_op holds its value outside ISSUE/CHECK; the datapath uses it only with try_load.
- Latency from key pulse (cycle n) in idle WAIT: latch at n; ISSUE at n+1; CHECK/commit at n+2; back in WAIT at n+3.
- enable dropping mid-transaction: the transaction completes, then the FSM holds in WAIT. Pending flags are kept.

Test Plan:
- Reset, then key_left at cycle 5 with chk_collided=0 -> try_load at 6 with try_op=3; commit at 7; state=WAIT at 8.
- key_rot, key_left and key_right in the same cycle with no collisions -> three transactions in order ROT, LEFT, RIGHT; exactly 3 commits over 9 cycles.
- GRAV_TICKS=8, no keys, chk_collided=0 -> DOWN try_load every 8+3 cycles. Then force chk_collided=1 on a DOWN -> place, clear, spawn on consecutive cycles, back to WAIT.
- key_drop together with key_rot -> PLACE is entered directly with no try_load; pend_rot is cleared at SPAWN and no ROT is issued afterwards.
- spawn_collided=1 at SPAWN -> game_over=1 and state=6; subsequent key pulses and gravity produce no strobes until rst_1plus.
- Assert rst_1plus asynchronously during CHECK -> state=0 and commit=0 immediately; first post-reset key_right is serviced normally.
